// File: rtl/posit_pkg.sv
// Shared posit defaults and special-value constants
// for the multiply pack/round pipeline.
package posit_pkg;

   localparam int N_DEF  = 8;
   localparam int ES_DEF = 4;
   localparam int RS_DEF = $clog2(N_DEF);

   // NaR: sign bit alone
   function automatic logic [31:0] nar_of(input int n);
      return 32'(1) << (n - 1);
   endfunction

   // largest positive posit: 0 then all ones
   function automatic logic [31:0] maxpos_of(input int n);
      return (32'(1) << (n - 1)) - 32'd1;
   endfunction

   // smallest positive posit: lsb alone
   function automatic logic [31:0] minpos_of(input int n);
      if (n > 0) return 32'd1;
      return 32'd0;
   endfunction

endpackage

// File: rtl/posit_mult_pack_if.sv
// Handshake bundle between multiply datapath,
// pack/round pipeline and downstream consumer.
interface posit_mult_pack_if
   import posit_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int ES = ES_DEF,
   parameter int RS = $clog2(N)
) ();

   logic              in_valid;
   logic              in_ready;
   logic [2*N-1:0]    mult_mant_n;
   logic [RS+ES+1:0]  total_eo;
   logic [ES-1:0]     e_o;
   logic [RS:0]       r_o;
   logic              inf;
   logic              zero;
   logic              sign;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      posit_out;

   modport master (
      output in_valid, mult_mant_n, total_eo, e_o,
      output r_o, inf, zero, sign, out_ready,
      input  in_ready, out_valid, posit_out
   );

   modport slave (
      input  in_valid, mult_mant_n, total_eo, e_o,
      input  r_o, inf, zero, sign, out_ready,
      output in_ready, out_valid, posit_out
   );

endinterface

// File: rtl/posit_round_rne.sv
// Second-stage combinational logic: RNE rounding,
// saturation, special values and sign complement.
module posit_round_rne
   import posit_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-2:0] body,
   input  logic         guard,
   input  logic         sticky,
   input  logic         sat,
   input  logic         neg,
   input  logic         inf,
   input  logic         zero,
   input  logic         sign,
   output logic [N-1:0] posit
);

   localparam logic [N-1:0] NAR  = N'(nar_of(N));
   localparam logic [N-1:0] MAXP = N'(maxpos_of(N));
   localparam logic [N-1:0] MINP = N'(minpos_of(N));

   logic         inc;
   logic [N-1:0] sum;
   logic [N-1:0] mag;
   logic [N-1:0] res;

   // round, clamp away from NaR/zero, then apply sign
   always_comb begin
      inc = guard & (body[0] | sticky);
      sum = {1'b0, body} + {{(N-1){1'b0}}, inc};
      mag = sum;
      if (sat)
         mag = neg ? MINP : MAXP;
      else if (sum == NAR)
         mag = MAXP;
      else if (sum == '0)
         mag = MINP;
      res = sign ? (~mag + {{(N-1){1'b0}}, 1'b1}) : mag;
      if (inf)
         posit = NAR;
      else if (zero)
         posit = '0;
      else
         posit = res;
   end

endmodule

// File: rtl/posit_mult_pack.sv
// Two-stage posit pack: S1 builds and aligns the
// regime/exponent/fraction string, S2 rounds and registers.
module posit_mult_pack
   import posit_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int ES = ES_DEF,
   parameter int RS = $clog2(N)
) (
   input logic              clk,
   input logic              rst_n,
   posit_mult_pack_if.slave bus
);

   localparam int FW = 2*N - 1;
   localparam int TW = 1 + ES + FW;
   localparam int WW = N - 1 + TW;
   localparam logic [RS:0] NM1 = (RS+1)'(N - 1);

   typedef struct packed {
      logic [N-2:0] body;
      logic         guard;
      logic         sticky;
      logic         sat;
      logic         neg;
      logic         inf;
      logic         zero;
      logic         sign;
   } s1_t;

   s1_t          s1_new;
   s1_t          s1_d, s1_q;
   logic         s1_valid_d, s1_valid_q;
   logic         out_valid_d, out_valid_q;
   logic [N-1:0] posit_d, posit_q;
   logic [N-1:0] rnd_out;
   logic         s1_adv;
   logic         in_ready;
   logic         unused_bits;

   logic [TW-1:0] tail;
   logic [WW-1:0] wide;
   logic [WW-1:0] shifted;
   logic [RS:0]   sh;

   assign unused_bits = bus.mult_mant_n[2*N-1]
                      ^ (^bus.total_eo[RS+ES:0]);

   // S1 assembly: fill bits, terminator, exponent, fraction,
   // then drop surplus fill so exactly r_o run bits remain
   always_comb begin
      s1_new.neg  = bus.total_eo[RS+ES+1];
      s1_new.inf  = bus.inf;
      s1_new.zero = bus.zero;
      s1_new.sign = bus.sign;
      s1_new.sat  = (bus.r_o >= NM1);
      tail = {s1_new.neg, bus.e_o, bus.mult_mant_n[2*N-2:0]};
      wide = {{(N-1){~s1_new.neg}}, tail};
      sh   = s1_new.sat ? '0 : (NM1 - bus.r_o);
      shifted = wide << sh;
      s1_new.body   = shifted[WW-1 -: N-1];
      s1_new.guard  = shifted[WW-N];
      s1_new.sticky = |shifted[WW-N-1:0];
   end

   // pipeline flow control
   always_comb begin
      s1_adv   = !out_valid_q | bus.out_ready;
      in_ready = !s1_valid_q | s1_adv;
   end

   // next-state for both stages
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      out_valid_d = out_valid_q;
      posit_d     = posit_q;
      if (in_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid)
            s1_d = s1_new;
      end
      if (s1_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q)
            posit_d = rnd_out;
      end
   end

   posit_round_rne #(.N(N)) u_round (
      .body   (s1_q.body),
      .guard  (s1_q.guard),
      .sticky (s1_q.sticky),
      .sat    (s1_q.sat),
      .neg    (s1_q.neg),
      .inf    (s1_q.inf),
      .zero   (s1_q.zero),
      .sign   (s1_q.sign),
      .posit  (rnd_out)
   );

   // stage registers, all cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         posit_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         out_valid_q <= out_valid_d;
         posit_q     <= posit_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.posit_out = posit_q;

endmodule

// File: tb/tb_posit_mult_pack.sv
// Scoreboard bench for posit_mult_pack: random and
// directed stimulus against a bit-string reference model.
module tb_posit_mult_pack;
   import posit_pkg::*;

   localparam int N  = 8;
   localparam int ES = 4;
   localparam int RS = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   posit_mult_pack_if #(.N(N), .ES(ES), .RS(RS)) bus ();

   posit_mult_pack #(.N(N), .ES(ES), .RS(RS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [N-1:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   bit bp_en = 0;
   int stall_cycles = 0;
   bit saw_stall = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
      end
   endtask

   // reference: write out the posit bit string and round it
   function automatic logic [N-1:0] model(
      input logic [2*N-1:0] m, input bit neg,
      input logic [ES-1:0] eo, input int ro,
      input bit fi, input bit fz, input bit fs);
      bit bits[$];
      int body, g, st, mag, res;
      if (fi) return N'(2**(N-1));
      if (fz) return '0;
      if (ro >= N-1) begin
         mag = neg ? 1 : 2**(N-1) - 1;
      end else begin
         for (int i = 0; i < ro; i++) bits.push_back(!neg);
         bits.push_back(neg);
         for (int i = ES-1; i >= 0; i--) bits.push_back(eo[i]);
         for (int i = 2*N-2; i >= 0; i--) bits.push_back(m[i]);
         body = 0;
         for (int i = 0; i < N-1; i++) body = body*2 + int'(bits[i]);
         g = int'(bits[N-1]);
         st = 0;
         for (int i = N; i < bits.size(); i++)
            if (bits[i]) st = 1;
         if (g == 1 && ((body % 2) == 1 || st == 1)) body++;
         if (body >= 2**(N-1)) body = 2**(N-1) - 1;
         if (body == 0) body = 1;
         mag = body;
      end
      res = fs ? (2**N - mag) % (2**N) : mag;
      return N'(res);
   endfunction

   // monitor: pop and compare on each transfer, watch holds
   logic [N-1:0] held;
   bit held_v = 0;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_v = 0;
      end else begin
         if (held_v)
            check("hold", {23'd0, bus.out_valid, bus.posit_out},
                  {23'd0, 1'b1, held});
         held_v = 0;
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               if (exp_q.size() == 0)
                  check("unexpected_out", 32'(bus.out_valid), 32'd0);
               else
                  check("posit_out", 32'(bus.posit_out),
                        32'(exp_q.pop_front()));
            end else begin
               held = bus.posit_out;
               held_v = 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (stall_cycles > 0) begin
         stall_cycles--;
         if (stall_cycles == 0) bus.out_ready = 1'b1;
      end else if (bp_en) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic send(input logic [2*N-1:0] m, input bit neg,
                       input logic [ES-1:0] eo, input int ro,
                       input bit fi, input bit fz, input bit fs);
      int k;
      int c;
      k = (neg ? -ro : ro - 1) * (2**ES) + int'(eo);
      bus.in_valid    = 1'b1;
      bus.mult_mant_n = m;
      bus.total_eo    = (RS+ES+2)'(k);
      bus.e_o         = eo;
      bus.r_o         = (RS+1)'(ro);
      bus.inf         = fi;
      bus.zero        = fz;
      bus.sign        = fs;
      c = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         saw_stall = 1;
         c++;
         if (c > 50) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
         end
         step();
      end
      exp_q.push_back(model(m, neg, eo, ro, fi, fz, fs));
      step();
   endtask

   task automatic drain();
      int c;
      bus.in_valid = 1'b0;
      c = 0;
      while (exp_q.size() != 0 && c < 300) begin
         step();
         c++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.mult_mant_n = '0;
      bus.total_eo    = '0;
      bus.e_o         = '0;
      bus.r_o         = '0;
      bus.inf         = 1'b0;
      bus.zero        = 1'b0;
      bus.sign        = 1'b0;
      bus.out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_posit_out", 32'(bus.posit_out), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      step();

      // 1.0 x 1.0 with latency check
      send(16'h8000, 0, 4'h0, 1, 0, 0, 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("lat_cycle1", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("lat_cycle2", 32'(bus.out_valid), 32'd1);
      step();

      send(16'h8000, 0, 4'h0, 1, 0, 0, 1);
      send(16'h8000, 0, 4'h0, 1, 1, 0, 0);
      send(16'h8000, 0, 4'h0, 1, 0, 1, 0);
      send(16'h8000, 0, 4'h0, 1, 1, 1, 1);
      send(16'h8000, 1, 4'hF, 1, 0, 0, 0);
      send(16'h8000, 0, 4'hF, 7, 0, 0, 0);
      send(16'h8000, 1, 4'h0, 7, 0, 0, 0);
      send(16'hA000, 0, 4'h0, 1, 0, 0, 0);
      send(16'hE000, 0, 4'h0, 1, 0, 0, 0);
      send(16'hFFFF, 0, 4'hF, 6, 0, 0, 0);
      send(16'hFFFF, 1, 4'hF, 6, 0, 0, 1);
      drain();

      // four back-to-back with a 3-cycle downstream stall
      saw_stall = 0;
      send(16'h8000, 0, 4'h3, 2, 0, 0, 0);
      send(16'hC000, 1, 4'h5, 1, 0, 0, 1);
      bus.out_ready = 1'b0;
      stall_cycles = 3;
      send(16'h9000, 0, 4'h1, 3, 0, 0, 0);
      send(16'hF000, 1, 4'h8, 2, 0, 0, 0);
      drain();
      check("in_ready_dropped", 32'(saw_stall), 32'd1);

      // reset with two results in flight
      bus.out_ready = 1'b0;
      send(16'h8000, 0, 4'h0, 1, 0, 0, 0);
      send(16'hC000, 0, 4'h2, 2, 0, 0, 0);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_posit_out", 32'(bus.posit_out), 32'd0);
      exp_q.delete();
      step();
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         @(negedge clk);
         check("postrst_quiet", 32'(bus.out_valid), 32'd0);
      end
      step();
      send(16'h8000, 0, 4'h0, 1, 0, 0, 0);
      drain();

      // randomized traffic with random backpressure
      bp_en = 1;
      for (int i = 0; i < 400; i++) begin
         logic [2*N-1:0] m;
         logic [ES-1:0] eo;
         int ro;
         int fl;
         bit neg;
         m   = 16'h8000 | 16'($urandom);
         neg = 1'($urandom_range(0, 1));
         eo  = 4'($urandom);
         if ($urandom_range(0, 7) == 0)
            ro = int'($urandom_range(7, 15));
         else
            ro = int'($urandom_range(1, 6));
         fl = int'($urandom_range(0, 15));
         send(m, neg, eo, ro, fl == 0, fl == 1,
              1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            step();
         end
      end
      bp_en = 0;
      bus.out_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/posit_mult_pack.md
POSIT_MULT_PACK -- requirements
Module: posit_mult_pack

Interface
REQ-001 SHALL have parameter N, default 8, posit word width.
REQ-002 SHALL have parameter ES, default 4, exponent field width.
REQ-003 SHALL have parameter RS, default $clog2(N), regime count width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream multiply-arithmetic result present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 mult_mant_n  input  2N  normalised mantissa product, hidden bit at [2N-1].
REQ-009 total_eo  input  RS+ES+2  signed total exponent; MSB = negative.
REQ-010 e_o  input  ES  exponent field (total_eo[ES-1:0]).
REQ-011 r_o  input  RS+1  regime run length, excluding the terminating bit.
REQ-012 inf, zero, sign  input  1 each  NaR flag, zero flag, result sign.
REQ-013 out_valid  output  1  packed posit available.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 posit_out  output  N  encoded rounded posit result.

Function
REQ-016 SHALL be a 2-stage pipeline: S1 regime/exponent/fraction assembly and right shift; S2 rounding, saturation, two's complement.
REQ-017 SHALL produce out_valid exactly 2 cycles after an accepted input when out_ready is held high; throughput 1 per cycle.
REQ-018 in_ready = !S1_valid | (S1 advances); S1 advances when !S2_valid | out_ready; S2 held while out_valid & !out_ready.
REQ-019 posit_out and out_valid SHALL stay stable while out_valid & !out_ready; no transfer lost or duplicated.
REQ-020 Regime: total_eo non-negative -> r_o ones then 0; negative -> r_o zeros then 1; length r_o+1.
REQ-021 Body = {regime, e_o, mult_mant_n[2N-2:0]}, truncated to N-1 bits after the sign position; guard = next bit, sticky = OR of remainder.
REQ-022 Rounding SHALL be round-to-nearest-even: increment if guard & (lsb | sticky).
REQ-023 r_o >= N-1 SHALL saturate: non-negative -> maxpos (0 then N-1 ones), negative -> minpos (N-1 zeros then 1); no rounding applied.
REQ-024 Rounding SHALL never produce NaR (clamp to maxpos) nor zero from nonzero input (clamp to minpos).
REQ-025 sign=1 SHALL two's-complement the N-bit result after rounding.
REQ-026 inf SHALL output 1 followed by N-1 zeros (NaR), priority over zero; zero SHALL output all zeros; sign ignored for both.
REQ-027 Flags SHALL travel with their data through both stages.

Reset
REQ-028 rst_n low SHALL asynchronously clear S1_valid, S2_valid, out_valid to 0 and posit_out to 0.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n deassertion.
REQ-030 Reset mid-operation SHALL discard all in-flight results; no out_valid until a new input is accepted.

Structure
REQ-031 Shared package posit_pkg SHALL hold N, ES, RS defaults and the NaR/maxpos/minpos constant functions.
REQ-032 One sub-module posit_round_rne (S2 rounding, saturation, complement) is natural; S1 inline.

Verification (N=8, ES=4)
REQ-033 1.0x1.0: mult_mant_n=16'h8000, total_eo=0, e_o=0, r_o=1, sign=0 -> posit_out=8'h40 two cycles later.
REQ-034 Same with sign=1 -> 8'hC0; inf=1 -> 8'h80; zero=1 -> 8'h00.
REQ-035 total_eo=-1, e_o=4'hF, r_o=1, mult_mant_n=16'h8000 -> 8'h3E; r_o=7 non-negative -> 8'h7F; r_o=7 negative -> 8'h01.
REQ-036 Tie cases: guard=1, sticky=0, lsb=0 -> no increment; lsb=1 -> increment.
REQ-037 Back-to-back 4 inputs, out_ready low 3 cycles mid-stream -> in_ready drops, outputs held, all 4 delivered in order.
REQ-038 rst_n pulsed low with 2 results in flight -> out_valid=0 immediately, nothing emitted afterwards until new input.
